// File: rtl/mmio_csr_regs_if.sv
// MMIO request/response bundle for the CSR block, plus FSM run status and a
// debug view of the FSM state.
interface mmio_csr_regs_if;
  // Handshake: requests carry no ready; any request with *_valid high in a
  // cycle is taken that cycle. rsp_valid is high for exactly one cycle per
  // response and the consumer must take it then.
  logic        mmio_rd_valid;
  logic        mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [1:0]  mmio_len;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        run_active;
  logic        done_pulse;
  logic [1:0]  fsm_state;

  modport master (
    output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
    input  rsp_valid, rsp_tid, rsp_data, run_active, done_pulse, fsm_state
  );

  modport slave (
    input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wr_data,
    output rsp_valid, rsp_tid, rsp_data, run_active, done_pulse, fsm_state
  );
endinterface

// File: rtl/mmio_csr_regs.sv
// Five-register MMIO CSR window (SCRATCH, CTRL, STATUS, RD_CNT, WR_CNT) with a
// two-stage read pipeline and a small IDLE/RUN/DONE run-length FSM.
module mmio_csr_regs #(
  parameter logic [15:0] REG_BASE = 16'h0010
) (
  input logic           clk,
  input logic           rst_n,
  mmio_csr_regs_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] run_cnt;
  logic [31:0] run_cnt_next;
  logic        done_q;
  logic        done_next;

  logic [63:0] scratch;
  logic [31:0] run_len;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  logic [15:0] addr_off;
  logic        in_window;
  logic [2:0]  reg_sel;
  logic        rd_hit;
  logic        wr_ok;
  logic        wr_scratch;
  logic        wr_ctrl;
  logic        start_req;
  logic [31:0] start_len;
  logic [63:0] rd_word;

  logic        s1_valid;
  logic [8:0]  s1_tid;
  logic [63:0] s1_data;
  logic        s2_valid;
  logic [8:0]  s2_tid;
  logic [63:0] s2_data;

  // Offset is only meaningful when addr >= REG_BASE; that test also keeps
  // windows near the top of the address space from wrapping.
  assign addr_off  = bus.mmio_addr - REG_BASE;
  assign in_window = (bus.mmio_addr >= REG_BASE) && (addr_off < 16'd10);
  assign reg_sel   = addr_off[3:1];

  assign rd_hit     = bus.mmio_rd_valid && in_window;
  assign wr_ok      = bus.mmio_wr_valid && in_window &&
                      (bus.mmio_len == 2'd1) && !addr_off[0];
  assign wr_scratch = wr_ok && (reg_sel == 3'd0);
  assign wr_ctrl    = wr_ok && (reg_sel == 3'd1);

  // START sees the RUN_LEN carried by the same write, not the stored one.
  assign start_req  = wr_ctrl && bus.mmio_wr_data[0];
  assign start_len  = bus.mmio_wr_data[47:16];

  always_comb begin
    rd_word = '0;
    if ((bus.mmio_len == 2'd1) && !addr_off[0]) begin
      case (reg_sel)
        3'd0:    rd_word = scratch;
        3'd1:    rd_word = {16'h0000, run_len, 16'h0000};
        3'd2:    rd_word = {run_cnt, 30'd0, (state == ST_DONE), (state == ST_RUN)};
        3'd3:    rd_word = {32'h0000_0000, rd_cnt};
        3'd4:    rd_word = {32'h0000_0000, wr_cnt};
        default: rd_word = '0;
      endcase
    end
  end

  // Register file and access counters. Reads sample rd_word in the request
  // cycle, so a same-cycle write or count update is seen only by later reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      run_len <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if (wr_scratch) scratch <= bus.mmio_wr_data;
      if (wr_ctrl)    run_len <= start_len;
      if (rd_hit)     rd_cnt  <= rd_cnt + 32'd1;
      if (wr_ok)      wr_cnt  <= wr_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tid   <= '0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_tid   <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= rd_hit;
      s1_tid   <= bus.mmio_tid;
      s1_data  <= rd_word;
      s2_valid <= s1_valid;
      s2_tid   <= s1_tid;
      s2_data  <= s1_data;
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_tid   = s2_tid;
  assign bus.rsp_data  = s2_data;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      run_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      run_cnt <= run_cnt_next;
      done_q  <= done_next;
    end
  end

  // FSM: next state. done_next marks every entry into DONE, including a
  // zero-length START issued while already in DONE.
  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    done_next    = 1'b0;
    case (state)
      ST_RUN: begin
        if (run_cnt == 32'd1) begin
          state_next   = ST_DONE;
          run_cnt_next = '0;
          done_next    = 1'b1;
        end else begin
          run_cnt_next = run_cnt - 32'd1;
        end
      end
      default: begin
        if (start_req) begin
          if (start_len != 32'd0) begin
            state_next   = ST_RUN;
            run_cnt_next = start_len;
          end else begin
            state_next   = ST_DONE;
            run_cnt_next = '0;
            done_next    = 1'b1;
          end
        end
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.run_active = (state == ST_RUN);
    bus.done_pulse = done_q;
    bus.fsm_state  = state;
  end

endmodule

// File: doc/mmio_csr_regs.md
MMIO_CSR_REGS -- requirements
Module: mmio_csr_regs

Interface
REQ-001 SHALL have parameter REG_BASE, default 16'h0010, the first owned MMIO address in 32-bit word units.
REQ-002 SHALL have ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- mmio_rd_valid, input, 1, MMIO read request this cycle.
- mmio_wr_valid, input, 1, MMIO write request this cycle.
- mmio_addr, input, 16, request address in 32-bit word units.
- mmio_len, input, 2, request length: 0 = 4 B, 1 = 8 B.
- mmio_tid, input, 9, request transaction ID.
- mmio_wr_data, input, 64, write data.
- rsp_valid, output, 1, read response valid, one cycle per response.
- rsp_tid, output, 9, echoed TID.
- rsp_data, output, 64, read data.
- run_active, output, 1, high while the FSM is in RUN.
- done_pulse, output, 1, one-cycle pulse on entry to DONE.

Function
REQ-003 SHALL own the window REG_BASE..REG_BASE+9.
- Each 64-bit register sits at an even offset.
- Requests outside the window SHALL produce no response and no side effect.
REQ-004 SHALL implement SCRATCH at offset +0: read/write, 64-bit.
REQ-005 SHALL implement CTRL at offset +2:
- bits[47:16] RUN_LEN, read/write.
- bit0 START: write-1 requests a run; reads as 0.
- All other bits read as 0.
REQ-006 SHALL implement STATUS at offset +4, read-only:
- bit0 BUSY (state == RUN).
- bit1 DONE (state == DONE).
- bits[63:32] remaining run count.
- Other bits 0.
REQ-007 SHALL implement RD_CNT at offset +6 and WR_CNT at offset +8, read-only.
- Each is a 32-bit counter zero-extended to 64 bits.
- RD_CNT counts in-window reads; WR_CNT counts accepted in-window writes.
- Both wrap from 0xFFFFFFFF to 0.
REQ-008 SHALL accept a write only when mmio_len == 1 and the offset is even.
- Other writes are ignored and not counted.
- Writes to read-only registers are counted but change nothing.
REQ-009 SHALL answer every in-window read exactly 2 cycles after mmio_rd_valid.
- rsp_tid equals the request TID.
- Reads at odd offsets or with mmio_len == 0 still respond, with rsp_data = 0.
REQ-010 SHALL accept back-to-back reads every cycle, giving one response per request, in order.
REQ-011 SHALL sample read data in the request cycle.
- A write in the same cycle takes effect the next cycle.
- The read therefore returns the pre-write value.
REQ-012 SHALL implement the FSM with states IDLE, RUN and DONE:
- IDLE + START with RUN_LEN > 0: go to RUN, counter loads RUN_LEN.
- IDLE + START with RUN_LEN == 0: go directly to DONE.
- RUN: counter decrements by 1 each cycle; on the cycle the counter equals 1, go to DONE with counter 0.
- RUN + START: ignored.
- DONE + START: same as from IDLE.
REQ-013 SHALL assert done_pulse for exactly the one cycle after the FSM enters DONE.
REQ-014 SHALL make a RUN_LEN value and START written in the same write act together, so START uses the new RUN_LEN.
REQ-015 SHALL not increment RD_CNT for a read it is serving.
- The read returns the count before that read.
- The counter increments one cycle later.

Reset
REQ-016 SHALL, while rst_n is low, asynchronously clear:
- all registers, counters and pipeline stages to 0;
- the FSM to IDLE;
- rsp_valid, run_active and done_pulse to 0.
REQ-017 SHALL drop any responses in flight when reset asserts mid-pipeline; none are emitted after release.
REQ-018 SHALL accept requests on the first rising edge after rst_n deasserts.

Verification
REQ-019 Write SCRATCH = 64'hDEADBEEF_CAFEF00D (len 1), then read it with tid 9'h1A -> rsp_valid exactly 2 cycles later, tid 9'h1A, data 64'hDEADBEEF_CAFEF00D; WR_CNT = 1.
REQ-020 Write CTRL with RUN_LEN = 5 and START = 1 -> run_active high for 5 cycles; done_pulse one cycle; STATUS reads 64'h2.
REQ-021 Write CTRL with RUN_LEN = 0 and START = 1 -> FSM to DONE directly; run_active never high; done_pulse one cycle.
REQ-022 Four back-to-back reads of SCRATCH, STATUS, RD_CNT, and address 0x0004 -> three responses on consecutive cycles in order; RD_CNT read returns 2; no response for 0x0004.
REQ-023 Pulse rst_n low one cycle after a read request -> no response emitted; SCRATCH reads 0 afterwards.
REQ-024 32-bit write (len 0) to SCRATCH -> value unchanged, WR_CNT unchanged.
